// File: rtl/cu_pkg.sv
// cu_pkg: state, instruction-class and control encodings shared by the multi-cycle sequencer
package cu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [2:0] {C_ALUI, C_R, C_BR, C_JMP, C_DIR, C_LD, C_ST} cls_e;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_LD = 2'b01, ALU_BR = 2'b10, ALU_R = 2'b11;
  localparam logic [1:0] PC_INC = 2'b00, PC_BR = 2'b01, PC_JMP = 2'b10;
  typedef struct packed {
    cls_e       cls;
    logic [1:0] alu_op;
    logic [2:0] alu_b;
    logic [2:0] imm_op;
    logic       alu_src;
    logic       reg_zero;
    logic       mem_to_reg;
  } ctrl_t;
endpackage

// File: rtl/cu_class_decode.sv
// cu_class_decode: maps the 5-bit major opcode to its instruction class and datapath control bundle
module cu_class_decode
  import cu_pkg::*;
(
  input  logic [4:0] op,
  output ctrl_t      ctrl
);
  cls_e cls;
  logic br, jmp, dir;
  always_comb begin
    cls = op == 5'b11111 ? C_R :
          op[4:3] == 2'b10 ? C_BR :
          (op == 5'b00000 || op[4:2] == 3'b010) ? C_JMP :
          op[4:2] == 3'b000 ? C_DIR :
          op[4:2] == 3'b001 ? C_LD :
          op[4:2] == 3'b110 ? C_ST : C_ALUI;
    br = cls == C_BR;
    jmp = cls == C_JMP;
    dir = cls == C_DIR;
    ctrl.cls = cls;
    ctrl.alu_op = cls == C_R ? ALU_R : br ? ALU_BR : cls == C_LD ? ALU_LD : ALU_ADD;
    ctrl.alu_b = {op[3], op[1], op[0]};
    ctrl.imm_op = {dir & op[0], jmp | br, dir};
    ctrl.alu_src = cls != C_R;
    ctrl.reg_zero = ~op[1] & op[0];
    ctrl.mem_to_reg = cls == C_LD;
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer with timed memory handshake; MCU_RETIRE_CNT_EN adds a retire counter
module multicycle_control_fsm
  import cu_pkg::*;
#(
  parameter int OPCODE_W  = 5,
  parameter int TIMEOUT_W = 4,
  parameter int RETIRE_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                br_taken,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic [2:0]          alu_b,
  output logic [2:0]          imm_op,
  output logic                reg_zero,
  output logic [2:0]          state,
  output logic                fault,
  output logic [RETIRE_W-1:0] instr_retired
);
  state_e               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d, dec;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 timeout, fetch_done, exec;
  cu_class_decode u_dec (.op(opcode[OPCODE_W-1 -: 5]), .ctrl(dec));
  always_comb begin
    mem_req = state_q == S_FETCH || state_q == S_MEM;
    timeout = mem_req && !mem_ready && wait_q == TIMEOUT_W'(2 ** TIMEOUT_W - 2);
    wait_d = (mem_req && !mem_ready) ? wait_q + TIMEOUT_W'(1) : '0;
    ctrl_d = state_q == S_DECODE ? dec : ctrl_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = ctrl_q.cls == C_BR ? S_FETCH :
                          (ctrl_q.cls == C_LD || ctrl_q.cls == C_ST) ? S_MEM : S_WB;
      S_MEM:    state_d = mem_ready ? (ctrl_q.cls == C_LD ? S_WB : S_FETCH) :
                          timeout ? S_TRAP : S_MEM;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
    fetch_done = state_q == S_FETCH && mem_ready;
    exec = state_q == S_EXEC;
    mem_we = state_q == S_MEM && ctrl_q.cls == C_ST;
    ir_write = fetch_done;
    pc_write = fetch_done || (exec && (ctrl_q.cls == C_JMP || (ctrl_q.cls == C_BR && br_taken)));
    pc_src = (exec && ctrl_q.cls == C_BR) ? PC_BR : (exec && ctrl_q.cls == C_JMP) ? PC_JMP : PC_INC;
    reg_write = state_q == S_WB;
    mem_to_reg = ctrl_q.mem_to_reg;
    alu_src = ctrl_q.alu_src;
    alu_op = ctrl_q.alu_op;
    alu_b = ctrl_q.alu_b;
    imm_op = ctrl_q.imm_op;
    reg_zero = ctrl_q.reg_zero;
    state = state_q;
    fault = state_q == S_TRAP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctrl_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      wait_q <= wait_d;
    end
  end
`ifdef MCU_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retired_q, retired_d;
  always_comb begin
    retired_d = retired_q + RETIRE_W'(state_d == S_FETCH &&
                (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_q <= '0;
    else retired_q <= retired_d;
  end
  assign instr_retired = retired_q;
`else
  assign instr_retired = '0;
`endif
endmodule
